// File: rtl/serial_code_pkg.sv
// Shared constants and helpers for the serial Excess-3 <-> BCD digit converter.
package serial_code_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BIT_CW  = 2;

    // Adjust constant: add or subtract 3 on every digit.
    localparam logic [DIGIT_W-1:0] K_ADJ = 4'b0011;

    localparam logic MODE_XS3_TO_BCD = 1'b0;
    localparam logic MODE_BCD_TO_XS3 = 1'b1;

    localparam logic [DIGIT_W-1:0] XS3_MIN = 4'd3;
    localparam logic [DIGIT_W-1:0] XS3_MAX = 4'd12;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // True when the input digit is not a legal code for the selected direction.
    function automatic logic code_illegal(input logic [DIGIT_W-1:0] digit, input logic mode);
        if (mode == MODE_XS3_TO_BCD) begin
            return (digit < XS3_MIN) || (digit > XS3_MAX);
        end
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/serial_adj_cell.sv
// One-bit serial add/subtract cell: combinational sum/difference bit, registered carry/borrow.
module serial_adj_cell
    import serial_code_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic k,
    input  logic mode,
    input  logic clear,
    input  logic en,
    output logic z,
    output logic cb_q
);

    logic cb_in;
    logic cb_next;
    logic cb_d;

    // Sum/difference bit and next carry (add) or borrow (subtract).
    always_comb begin
        cb_in = clear ? 1'b0 : cb_q;
        z     = x ^ k ^ cb_in;
        if (mode == MODE_BCD_TO_XS3) begin
            cb_next = (x & k) | (x & cb_in) | (k & cb_in);
        end else begin
            cb_next = (~x & k) | (~x & cb_in) | (k & cb_in);
        end
        cb_d = en ? cb_next : cb_q;
    end

    // Carry/borrow register; only moves on an accepted bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cb_q <= 1'b0;
        end else begin
            cb_q <= cb_d;
        end
    end

endmodule

// File: rtl/serial_code_conv.sv
// Bit-serial Excess-3 <-> BCD converter with per-digit error flags and word assembly.
module serial_code_conv
    import serial_code_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned CW      = BIT_CW
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   X,
    input  logic                   In_Valid,
    input  logic                   Mode,
    output logic                   Z,
    output logic                   Z_Valid,
    output logic                   Digit_Done,
    output logic                   Digit_Err,
    output logic                   Word_Done,
    output logic                   Word_Err,
    output logic [4*NDIGITS-1:0]   Word_Out
);

    localparam int unsigned DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [CW-1:0]          bit_q, bit_d;
    logic [DW-1:0]          digit_idx_q, digit_idx_d;
    logic                   mode_q, mode_d;
    logic [DIGIT_W-2:0]     shift_q, shift_d;
    logic [DIGIT_W-2:0]     hist_q, hist_d;
    logic                   err_acc_q, err_acc_d;
    logic [4*NDIGITS-1:0]   slots_q, slots_d;
    logic                   digit_done_q, digit_done_d;
    logic                   digit_err_q, digit_err_d;
    logic                   word_done_q, word_done_d;
    logic                   word_err_q, word_err_d;
    logic [4*NDIGITS-1:0]   word_out_q, word_out_d;

    logic                   accept;
    logic                   first_bit;
    logic                   last_bit;
    logic                   last_digit;
    logic                   eff_mode;
    logic                   k_bit;
    logic                   z_bit;
    logic                   cb_unused;
    logic [DIGIT_W-1:0]     in_digit;
    logic [DIGIT_W-1:0]     conv_digit;
    logic                   digit_bad;

    // Bit-position decode and effective mode (Mode is only honoured at bit 0).
    always_comb begin
        accept     = In_Valid & ~Rst;
        first_bit  = (bit_q == '0);
        last_bit   = (bit_q == CW'(DIGIT_W - 1));
        last_digit = (digit_idx_q == DW'(NDIGITS - 1));
        eff_mode   = first_bit ? Mode : mode_q;
        k_bit      = K_ADJ[bit_q];
        in_digit   = {X, hist_q};
        conv_digit = {z_bit, shift_q};
        digit_bad  = code_illegal(in_digit, eff_mode);
    end

    serial_adj_cell u_cell (
        .clk   (Clk),
        .rst   (Rst),
        .x     (X),
        .k     (k_bit),
        .mode  (eff_mode),
        .clear (first_bit),
        .en    (accept),
        .z     (z_bit),
        .cb_q  (cb_unused)
    );

    // Next-state for counters, shift/history registers, error accumulation and word assembly.
    always_comb begin
        bit_d        = bit_q;
        digit_idx_d  = digit_idx_q;
        mode_d       = mode_q;
        shift_d      = shift_q;
        hist_d       = hist_q;
        err_acc_d    = err_acc_q;
        slots_d      = slots_q;
        digit_done_d = 1'b0;
        digit_err_d  = 1'b0;
        word_done_d  = 1'b0;
        word_err_d   = 1'b0;
        word_out_d   = word_out_q;

        if (accept) begin
            shift_d = {z_bit, shift_q[DIGIT_W-2:1]};
            hist_d  = {X, hist_q[DIGIT_W-2:1]};
            bit_d   = bit_q + 1'b1;
            if (first_bit) begin
                mode_d = Mode;
            end
            if (last_bit) begin
                digit_done_d = 1'b1;
                digit_err_d  = digit_bad;
                slots_d[int'(digit_idx_q)*DIGIT_W +: DIGIT_W] = conv_digit;
                if (last_digit) begin
                    digit_idx_d = '0;
                    word_done_d = 1'b1;
                    word_err_d  = err_acc_q | digit_bad;
                    word_out_d  = slots_d;
                    err_acc_d   = 1'b0;
                end else begin
                    digit_idx_d = digit_idx_q + 1'b1;
                    err_acc_d   = err_acc_q | digit_bad;
                end
            end
        end
    end

    // State registers with synchronous reset; reset discards any partial digit or word.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_q        <= '0;
            digit_idx_q  <= '0;
            mode_q       <= 1'b0;
            shift_q      <= '0;
            hist_q       <= '0;
            err_acc_q    <= 1'b0;
            slots_q      <= '0;
            digit_done_q <= 1'b0;
            digit_err_q  <= 1'b0;
            word_done_q  <= 1'b0;
            word_err_q   <= 1'b0;
            word_out_q   <= '0;
        end else begin
            bit_q        <= bit_d;
            digit_idx_q  <= digit_idx_d;
            mode_q       <= mode_d;
            shift_q      <= shift_d;
            hist_q       <= hist_d;
            err_acc_q    <= err_acc_d;
            slots_q      <= slots_d;
            digit_done_q <= digit_done_d;
            digit_err_q  <= digit_err_d;
            word_done_q  <= word_done_d;
            word_err_q   <= word_err_d;
            word_out_q   <= word_out_d;
        end
    end

    // Output mapping; Z is Mealy from the live input bit.
    always_comb begin
        Z          = z_bit;
        Z_Valid    = accept;
        Digit_Done = digit_done_q;
        Digit_Err  = digit_err_q;
        Word_Done  = word_done_q;
        Word_Err   = word_err_q;
        Word_Out   = word_out_q;
    end

endmodule

// File: doc/serial_code_conv.md
Name: serial_code_conv

Overview:
- Parametrised successor to the team's single-digit serial Excess-3→BCD converter.
- Converts a bit-serial, LSB-first stream of 4-bit digits in either direction:
  - Mode=0: Excess-3 → BCD (subtract 3).
  - Mode=1: BCD → Excess-3 (add 3).
- Adds a valid qualifier, per-digit code-error detection, and assembly of NDIGITS converted digits into a parallel word with a done pulse.
- Sits between a serial digit source and parallel consumers (display or compare logic).

Parameters:
- NDIGITS, 4, digits per word (≥1).
- CW, 2, bit-counter width; fixed at 2 for 4-bit digits, exposed for the package constant only.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- X  in  1  serial data bit, LSB first.
- In_Valid  in  1  X is valid this cycle; the bit is accepted on the posedge.
- Mode  in  1  0 = XS3→BCD, 1 = BCD→XS3; latched at bit 0 of each digit.
- Z  out  1  converted bit, combinational (Mealy) from X, bit index and carry/borrow.
- Z_Valid  out  1  = In_Valid & ~Rst.
- Digit_Done  out  1  registered one-cycle pulse after the 4th bit of a digit is accepted.
- Digit_Err  out  1  registered; valid with Digit_Done; 1 if the input digit was an illegal code.
- Word_Done  out  1  registered one-cycle pulse after the last digit of a word.
- Word_Err  out  1  valid with Word_Done; OR of every Digit_Err in the word.
- Word_Out  out  4*NDIGITS  converted word; digit 0 in bits [3:0]; updated only with Word_Done.

Behaviour:
- Reset (Rst=1 at posedge): bit_idx=0, digit_idx=0, carry=0, err_acc=0, all registered outputs 0, Word_Out=0.
  - Applies mid-digit or mid-word; the partial digit or word is discarded with no Done pulse.
  - Z_Valid=0 while Rst=1.
- Adjust constant K=4'b0011, so k[bit_idx] = 1 for bits 0–1 and 0 for bits 2–3.
  - Effective mode = Mode at bit 0, the latched value for bits 1–3.
- Mode 0 (subtract):
  - Z = X^k^b.
  - b_next = (~X&k)|(~X&b)|(k&b).
- Mode 1 (add):
  - Z = X^k^c.
  - c_next = (X&k)|(X&c)|(k&c).
- Carry/borrow clears to 0 at bit 0 of every digit; it never propagates across digits.
- In_Valid=0: all state holds, Z is don't-care, no Done pulses are generated. Stalls are allowed between any two bits.
- Per accepted bit:
  - Shift Z into the digit shift register.
  - Store X in the input history register.
  - Increment bit_idx, wrapping 3→0.
- On the 4th accepted bit, the next cycle raises:
  - Digit_Done=1.
  - Digit_Err=1 if the input digit is illegal:
    - Mode 0: input ∉ 3..12.
    - Mode 1: input > 9.
  - The converted digit is written into slot digit_idx; digit_idx increments.
  - Output nibble for an illegal digit = the raw 4-bit adder/subtractor result (modulo 16), unguarded.
- When digit_idx wraps NDIGITS-1→0, the same cycle as that Digit_Done also raises:
  - Word_Done=1.
  - Word_Out = assembled word.
  - Word_Err = err_acc | current Digit_Err.
  - err_acc clears.
- A new digit's bit 0 may be accepted in the same cycle a Done pulse is high; throughput is 1 bit/cycle.
- Rst and In_Valid both high: reset wins and the bit is dropped.

Decomposition:
- Package serial_code_pkg:
  - DIGIT_W=4.
  - K_ADJ=4'b0011.
  - MODE_XS3_TO_BCD=1'b0, MODE_BCD_TO_XS3=1'b1.
  - Legal-range constants XS3_MIN=3, XS3_MAX=12, BCD_MAX=9.
- Sub-module serial_adj_cell: 1-bit add/subtract cell.
  - Inputs: x, k, mode, clear, en.
  - Outputs: combinational z; registered carry/borrow.
- Top module holds bit/digit counters, shift and history registers, error logic and word assembly.

Test Plan:
1. Mode=0, NDIGITS=1, sweep XS3 0011..1100 LSB first, In_Valid=1 → Z stream and Word_Out = 0000..1001, Digit_Err=0, one Word_Done per digit.
2. Mode=1, BCD 0101 → Z bits 0,0,0,1 (1000); BCD 1010 → Digit_Err=1, Word_Out=1101.
3. Mode=0, XS3 0001 → Digit_Err=1, Word_Out=1110; XS3 1101 → Digit_Err=1.
4. NDIGITS=2, Mode=0, digits 0100 then 0111 → Word_Out=8'h41, Word_Done once, Word_Err=0; repeat with 2nd digit 1111 → Word_Err=1.
5. Random In_Valid gaps of 1–3 cycles inside XS3 1100 → Word_Out=1001; no Done pulse during the gaps.
6. Rst=1 after 2 bits of a digit, then a full XS3 0110 → Word_Out=0011, no spurious Done, Mode toggled mid-digit ignored.
